// File: rtl/idelay_tap_scanner.sv
// IDELAYE2 VAR_LOAD tap scanner: sweeps taps 0..31, finds the widest error-free window, loads its centre.
// Optional: define IDELAY_SCAN_READBACK_EN to check CNTVALUEOUT after every load and add the rb_err_o port.
module idelay_tap_scanner #(
  parameter int SETTLE_CYCLES = 16,
  parameter int SAMPLE_CYCLES = 256,
  parameter int ERR_W         = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cal_rdy_i,
  input  logic       start_i,
  input  logic       data_in_i,
  input  logic       ref_in_i,
  output logic       dly_ld_o,
  output logic [4:0] dly_cntvalue_o,
  input  logic [4:0] dly_cntout_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       aborted_o,
  output logic [4:0] best_tap_o,
  output logic       best_valid_o,
  output logic [5:0] win_len_o
`ifdef IDELAY_SCAN_READBACK_EN
  ,
  output logic       rb_err_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_SAMPLE,
    S_EVAL,
    S_APPLY,
    S_APPLYWAIT
  } state_t;

  localparam logic [15:0]      SETTLE_INIT = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0]      SAMPLE_INIT = 16'(SAMPLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;
  localparam logic [4:0]       LAST_TAP    = 5'd31;

  state_t           state_q;
  logic [4:0]       tap_q;
  logic [15:0]      timer_q;
  logic [ERR_W-1:0] err_q;
  logic             run_open_q;
  logic [4:0]       run_start_q;
  logic [5:0]       run_len_q;
  logic [4:0]       best_start_q;
  logic [5:0]       best_len_q;

  logic             dly_ld_q;
  logic [4:0]       cntval_q;
  logic             busy_q;
  logic             done_q;
  logic             aborted_q;
  logic [4:0]       best_tap_q;
  logic             best_valid_q;
  logic [5:0]       win_len_q;

  logic [ERR_W-1:0] err_d;
  logic             tap_clean;
  logic [4:0]       ext_start_d;
  logic [5:0]       ext_len_d;
  logic             take_best;
  logic [4:0]       best_start_d;
  logic [5:0]       best_len_d;
  logic [4:0]       centre_d;

`ifdef IDELAY_SCAN_READBACK_EN
  logic rb_err_q;
  logic rb_mis;

  assign rb_mis = ((state_q == S_SETTLE && timer_q == SETTLE_INIT) || state_q == S_APPLYWAIT)
                  && (dly_cntout_i != cntval_q);
  assign rb_err_o = rb_err_q;
`else
  logic unused_cntout;
  assign unused_cntout = ^dly_cntout_i;
`endif

  always_comb begin
    err_d = (err_q == ERR_MAX) ? err_q
                               : err_q + {{(ERR_W-1){1'b0}}, (data_in_i ^ ref_in_i)};
    tap_clean = (err_q == '0);

    // Candidate run: the open run extended by this tap when clean, else the open run as it stands.
    ext_start_d = run_start_q;
    ext_len_d   = run_len_q;
    if (tap_clean) begin
      ext_start_d = run_open_q ? run_start_q : tap_q;
      ext_len_d   = run_open_q ? run_len_q + 6'd1 : 6'd1;
    end

    take_best    = (!tap_clean || tap_q == LAST_TAP) && (ext_len_d > best_len_q);
    best_start_d = take_best ? ext_start_d : best_start_q;
    best_len_d   = take_best ? ext_len_d   : best_len_q;
    centre_d     = (best_len_d == 6'd0) ? 5'd0
                                        : best_start_d + 5'((best_len_d - 6'd1) >> 1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      tap_q        <= '0;
      timer_q      <= '0;
      err_q        <= '0;
      run_open_q   <= 1'b0;
      run_start_q  <= '0;
      run_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
      dly_ld_q     <= 1'b0;
      cntval_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      best_tap_q   <= '0;
      best_valid_q <= 1'b0;
      win_len_q    <= '0;
`ifdef IDELAY_SCAN_READBACK_EN
      rb_err_q     <= 1'b0;
`endif
    end else begin
      dly_ld_q  <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;

      if (state_q != S_IDLE && !cal_rdy_i) begin
        state_q      <= S_IDLE;
        busy_q       <= 1'b0;
        aborted_q    <= 1'b1;
        best_valid_q <= 1'b0;
        win_len_q    <= '0;
        run_open_q   <= 1'b0;
        run_len_q    <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_i && cal_rdy_i) begin
              state_q      <= S_LOAD;
              busy_q       <= 1'b1;
              tap_q        <= '0;
              err_q        <= '0;
              best_valid_q <= 1'b0;
              win_len_q    <= '0;
              run_open_q   <= 1'b0;
              run_start_q  <= '0;
              run_len_q    <= '0;
              best_start_q <= '0;
              best_len_q   <= '0;
              dly_ld_q     <= 1'b1;
              cntval_q     <= '0;
`ifdef IDELAY_SCAN_READBACK_EN
              rb_err_q     <= 1'b0;
`endif
            end
          end

          S_LOAD: begin
            state_q <= S_SETTLE;
            timer_q <= SETTLE_INIT;
            err_q   <= '0;
          end

          S_SETTLE: begin
`ifdef IDELAY_SCAN_READBACK_EN
            if (rb_mis) begin
              err_q    <= ERR_MAX;
              rb_err_q <= 1'b1;
            end
`endif
            if (timer_q == '0) begin
              state_q <= S_SAMPLE;
              timer_q <= SAMPLE_INIT;
            end else begin
              timer_q <= timer_q - 16'd1;
            end
          end

          S_SAMPLE: begin
            err_q <= err_d;
            if (timer_q == '0) begin
              state_q <= S_EVAL;
            end else begin
              timer_q <= timer_q - 16'd1;
            end
          end

          S_EVAL: begin
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
            if (tap_clean) begin
              run_open_q  <= 1'b1;
              run_start_q <= ext_start_d;
              run_len_q   <= ext_len_d;
            end else begin
              run_open_q  <= 1'b0;
              run_len_q   <= '0;
            end
            dly_ld_q <= 1'b1;
            if (tap_q == LAST_TAP) begin
              // Window may end on the last tap; it was closed into best_*_d above.
              state_q      <= S_APPLY;
              cntval_q     <= centre_d;
              best_tap_q   <= centre_d;
              win_len_q    <= best_len_d;
              best_valid_q <= (best_len_d != 6'd0);
              run_open_q   <= 1'b0;
              run_len_q    <= '0;
            end else begin
              state_q  <= S_LOAD;
              tap_q    <= tap_q + 5'd1;
              cntval_q <= tap_q + 5'd1;
            end
          end

          S_APPLY: begin
            state_q <= S_APPLYWAIT;
          end

          S_APPLYWAIT: begin
`ifdef IDELAY_SCAN_READBACK_EN
            if (rb_mis) rb_err_q <= 1'b1;
`endif
            state_q <= S_IDLE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end

          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dly_ld_o       = dly_ld_q;
  assign dly_cntvalue_o = cntval_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign aborted_o      = aborted_q;
  assign best_tap_o     = best_tap_q;
  assign best_valid_o   = best_valid_q;
  assign win_len_o      = win_len_q;

endmodule
